// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I-cache (port 0) and D-cache (port 1) block requests.
// Each granted block is sequenced as WORDS word beats on a single memory port.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   Req0,
    input  logic                                   Req1,
    input  logic                                   Wr0,
    input  logic                                   Wr1,
    input  logic [ADDR_W-$clog2(WORDS)-3:0]        A0,
    input  logic [ADDR_W-$clog2(WORDS)-3:0]        A1,
    input  logic [WORDS*WORD_W-1:0]                WData0,
    input  logic [WORDS*WORD_W-1:0]                WData1,
    output logic                                   Rdy0,
    output logic                                   Rdy1,
    output logic [WORDS*WORD_W-1:0]                RData,
    output logic                                   Mem_Req,
    output logic                                   Mem_Wr,
    output logic [ADDR_W-1:0]                      Mem_Addr,
    output logic [WORD_W-1:0]                      Mem_WData,
    input  logic [WORD_W-1:0]                      Mem_RData,
    input  logic                                   Mem_Ack
);
    localparam int BW    = $clog2(WORDS);
    localparam int OFS   = BW + 2;
    localparam int BLK_W = ADDR_W - OFS;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

    state_e                    state_q, state_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic                      owner_q, owner_d;
    logic                      lastGnt_q, lastGnt_d;
    logic                      wr_q, wr_d;
    logic [BLK_W-1:0]          addr_q, addr_d;
    logic [WORDS*WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORDS*WORD_W-1:0]   buf_q, buf_d;
    logic                      gnt;

    // lastGnt resets to 1 so that port 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            owner_q   <= 1'b0;
            lastGnt_q <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            owner_q   <= owner_d;
            lastGnt_q <= lastGnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            buf_q     <= buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        owner_d   = owner_q;
        lastGnt_d = lastGnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        buf_d     = buf_q;
        gnt       = 1'b0;
        Mem_Req   = 1'b0;
        Mem_Wr    = 1'b0;
        Mem_Addr  = '0;
        Mem_WData = '0;

        unique case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    // A lone requester wins outright; a tie goes to the port not served last.
                    gnt       = (Req0 && Req1) ? ~lastGnt_q : Req1;
                    owner_d   = gnt;
                    lastGnt_d = gnt;
                    wr_d      = gnt ? Wr1 : Wr0;
                    addr_d    = gnt ? A1 : A0;
                    wdata_d   = gnt ? WData1 : WData0;
                    beat_d    = '0;
                    state_d   = XFER;
                end
            end
            XFER: begin
                Mem_Req   = 1'b1;
                Mem_Wr    = wr_q;
                Mem_Addr  = {addr_q, beat_q, 2'b00};
                Mem_WData = wdata_q[beat_q*WORD_W +: WORD_W];
                if (Mem_Ack) begin
                    if (!wr_q) begin
                        buf_d[beat_q*WORD_W +: WORD_W] = Mem_RData;
                    end
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Rdy0  = (state_q == DONE) && !owner_q;
    assign Rdy1  = (state_q == DONE) &&  owner_q;
    assign RData = buf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected beats and completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;
    localparam int BLKW = 26;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [1:0]   rdy;
        logic         chk;
        logic [127:0] data;
        int           expCyc;
    } rdy_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              Req0 = 1'b0, Req1 = 1'b0;
    logic              Wr0 = 1'b0, Wr1 = 1'b0;
    logic [BLKW-1:0]   A0 = '0, A1 = '0;
    logic [127:0]      WData0 = '0, WData1 = '0;
    logic              Rdy0, Rdy1;
    logic [127:0]      RData;
    logic              Mem_Req, Mem_Wr;
    logic [31:0]       Mem_Addr, Mem_WData;
    logic [31:0]       Mem_RData = '0;
    logic              Mem_Ack = 1'b0;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    waitCycles = 0;
    int    ackCnt = 0;
    logic  spurious = 1'b0;
    beat_t beatQ[$];
    rdy_t  rdyQ[$];

    localparam logic [127:0] RD0 = 128'h11111113_11111112_11111111_11111110;
    localparam logic [127:0] RD1 = 128'h22222223_22222222_22222221_22222220;
    localparam logic [127:0] WB1 = 128'h0D0D0D03_0D0D0D02_0D0D0D01_0D0D0D00;
    localparam logic [127:0] FILL123 = 128'h000123A3_000123A2_000123A1_000123A0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
        .A0(A0), .A1(A1), .WData0(WData0), .WData1(WData1),
        .Rdy0(Rdy0), .Rdy1(Rdy1), .RData(RData),
        .Mem_Req(Mem_Req), .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr),
        .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[27:4], 8'hA0 + {6'b0, a[3:2]}};
    endfunction

    function automatic logic [127:0] fillBlock(input logic [BLKW-1:0] blk);
        logic [127:0] r;
        logic [1:0]   b;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            b = 2'(i);
            r[i*32 +: 32] = memWord({blk, b, 2'b00});
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic wr, input logic [BLKW-1:0] blk,
                                 input logic [127:0] wdata);
        if (port) begin
            Req1 = 1'b1; Wr1 = wr; A1 = blk; WData1 = wdata;
        end else begin
            Req0 = 1'b1; Wr0 = wr; A0 = blk; WData0 = wdata;
        end
    endtask

    task automatic pushBeats(input logic wr, input logic [BLKW-1:0] blk, input logic [127:0] wdata,
                             input int n);
        beat_t    e;
        logic [1:0] b;
        for (int i = 0; i < n; i++) begin
            b       = 2'(i);
            e.wr    = wr;
            e.addr  = {blk, b, 2'b00};
            e.wdata = wdata[i*32 +: 32];
            beatQ.push_back(e);
        end
    endtask

    task automatic pushRdy(input logic port, input logic chk, input logic [127:0] data, input int expCyc);
        rdy_t e;
        e.rdy    = port ? 2'b10 : 2'b01;
        e.chk    = chk;
        e.data   = data;
        e.expCyc = expCyc;
        rdyQ.push_back(e);
    endtask

    // Waits for n completion pulses, drops both requests on the last one, then steps into IDLE.
    task automatic waitRdy(input int n, input string name);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 300) begin
            @(negedge clk);
            budget++;
            if (Rdy0 || Rdy1) seen++;
        end
        Req0 = 1'b0;
        Req1 = 1'b0;
        checkOutput(name, 128'(seen), 128'(n));
        @(negedge clk);
    endtask

    // Memory model: acks after waitCycles idle cycles; spurious mode acks every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (spurious) begin
                Mem_Ack   = 1'b1;
                Mem_RData = Mem_Req ? memWord(Mem_Addr) : 32'hDEADBEEF;
            end else if (Mem_Req) begin
                if (ackCnt >= waitCycles) begin
                    Mem_Ack   = 1'b1;
                    Mem_RData = memWord(Mem_Addr);
                    ackCnt    = 0;
                end else begin
                    Mem_Ack   = 1'b0;
                    Mem_RData = 32'hBAD0BAD0;
                    ackCnt++;
                end
            end else begin
                Mem_Ack   = 1'b0;
                Mem_RData = 32'hBAD0BAD0;
                ackCnt    = 0;
            end
        end
    end

    // Monitor: every memory cycle is compared with the head beat, popped on ack.
    initial begin
        beat_t b;
        rdy_t  r;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) continue;
            if (Mem_Req) begin
                if (beatQ.size() == 0) begin
                    checkOutput("unexpectedBeat", {63'b0, Mem_Wr, Mem_Addr, Mem_WData}, 128'b0);
                end else begin
                    b = beatQ[0];
                    checkOutput("memBeat", {63'b0, Mem_Wr, Mem_Addr, Mem_WData},
                                {63'b0, b.wr, b.addr, b.wdata});
                    if (Mem_Ack) void'(beatQ.pop_front());
                end
            end
            if (Rdy0 || Rdy1) begin
                if (rdyQ.size() == 0) begin
                    checkOutput("unexpectedRdy", {126'b0, Rdy1, Rdy0}, 128'b0);
                end else begin
                    r = rdyQ.pop_front();
                    checkOutput("rdyPort", {126'b0, Rdy1, Rdy0}, {126'b0, r.rdy});
                    if (r.expCyc >= 0) checkOutput("rdyCycle", 128'(cyc), 128'(r.expCyc));
                    if (r.chk) checkOutput("rdyData", RData, r.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int budget;
        #12;
        checkOutput("resetMemReq", {127'b0, Mem_Req}, 128'b0);
        checkOutput("resetMemAddr", {96'b0, Mem_Addr}, 128'b0);
        checkOutput("resetRdy", {126'b0, Rdy1, Rdy0}, 128'b0);
        checkOutput("resetRData", RData, 128'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Tie three times from reset: grants 0, 1, 0, each immediately after the previous DONE.
        n = cyc;
        applyStimulus(1'b0, 1'b0, 26'h0000010, RD0);
        applyStimulus(1'b1, 1'b0, 26'h0000020, RD1);
        pushBeats(1'b0, 26'h0000010, RD0, 4); pushRdy(1'b0, 1'b1, fillBlock(26'h0000010), n + 5);
        pushBeats(1'b0, 26'h0000020, RD1, 4); pushRdy(1'b1, 1'b1, fillBlock(26'h0000020), n + 11);
        pushBeats(1'b0, 26'h0000010, RD0, 4); pushRdy(1'b0, 1'b1, fillBlock(26'h0000010), n + 17);
        waitRdy(3, "roundRobinDone");

        // Single zero-wait fill on port 0.
        n = cyc;
        applyStimulus(1'b0, 1'b0, 26'h0000123, RD0);
        pushBeats(1'b0, 26'h0000123, RD0, 4);
        pushRdy(1'b0, 1'b1, FILL123, n + 5);
        waitRdy(1, "fillDone");

        // Spurious acks while idle leave buffer and state alone.
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        checkOutput("idleAckRData", RData, FILL123);
        checkOutput("idleAckMemReq", {127'b0, Mem_Req}, 128'b0);
        spurious = 1'b0;
        @(negedge clk);

        // Write-back on port 1 with two wait cycles per beat; the fill buffer is untouched.
        waitCycles = 2;
        n = cyc;
        applyStimulus(1'b1, 1'b1, 26'h00003C5, WB1);
        pushBeats(1'b1, 26'h00003C5, WB1, 4);
        pushRdy(1'b1, 1'b1, FILL123, n + 13);
        waitRdy(1, "writeBackDone");

        // Req0 dropped during beat 1: the transfer still runs to completion.
        waitCycles = 1;
        applyStimulus(1'b0, 1'b0, 26'h00000AB, RD0);
        pushBeats(1'b0, 26'h00000AB, RD0, 4);
        pushRdy(1'b0, 1'b1, fillBlock(26'h00000AB), -1);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(Mem_Req && Mem_Addr[3:2] == 2'd1) && budget < 100);
        checkOutput("dropReachBeat1", {127'b0, Mem_Req}, 128'b1);
        Req0 = 1'b0;
        waitRdy(1, "dropDone");

        // Spurious acks through a whole fill, including its DONE cycle and the following IDLE.
        waitCycles = 0;
        spurious = 1'b1;
        n = cyc;
        applyStimulus(1'b0, 1'b0, 26'h0000200, RD0);
        pushBeats(1'b0, 26'h0000200, RD0, 4);
        pushRdy(1'b0, 1'b1, fillBlock(26'h0000200), n + 5);
        waitRdy(1, "spuriousDone");
        repeat (2) @(negedge clk);
        #2;
        checkOutput("doneAckRData", RData, fillBlock(26'h0000200));
        checkOutput("doneAckMemReq", {127'b0, Mem_Req}, 128'b0);
        spurious = 1'b0;
        @(negedge clk);

        // Reset during beat 2 kills the transfer at once with no completion pulse.
        waitCycles = 3;
        applyStimulus(1'b0, 1'b0, 26'h0000077, RD0);
        pushBeats(1'b0, 26'h0000077, RD0, 3);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(Mem_Req && Mem_Addr[3:2] == 2'd2) && budget < 100);
        checkOutput("resetReachBeat2", {127'b0, Mem_Req}, 128'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midResetMemReq", {127'b0, Mem_Req}, 128'b0);
        checkOutput("midResetRdy", {126'b0, Rdy1, Rdy0}, 128'b0);
        checkOutput("midResetRData", RData, 128'b0);
        checkOutput("midResetPending", 128'(beatQ.size()), 128'd1);
        Req0 = 1'b0;
        repeat (2) @(negedge clk);
        beatQ.delete();
        rst = 1'b1;

        // After reset a lone Req1 starts cleanly at beat 0.
        waitCycles = 0;
        n = cyc;
        applyStimulus(1'b1, 1'b0, 26'h0000456, RD1);
        pushBeats(1'b0, 26'h0000456, RD1, 4);
        pushRdy(1'b1, 1'b1, fillBlock(26'h0000456), n + 5);
        waitRdy(1, "postResetDone");

        repeat (3) @(negedge clk);
        checkOutput("beatQueueEmpty", 128'(beatQ.size()), 128'd0);
        checkOutput("rdyQueueEmpty", 128'(rdyQ.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port block-transfer arbiter and sequencer between the instruction-cache and data-cache controllers and a single word-wide memory port. Each cache controller issues a block request with its Req_Low/Wr_Low/Rdy_Low handshake. The arbiter grants one requester at a time, round-robin. It splits each block into WORDS sequential word beats on the memory port, and collects read words into a block buffer. When the last beat completes, it returns a one-cycle ready to the owner.

## Interface
- ADDR_W, 32, byte-address width
- WORD_W, 32, memory word width
- WORDS, 4, words per cache block; must be a power of two; beat index width BW = log2(WORDS)
- OFS = BW+2, block-offset bits; block address is A[ADDR_W-1:OFS]

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- Req0 / Req1  in  1  block request from I-cache (port 0) / D-cache (port 1)
- Wr0 / Wr1  in  1  1 = write-back of block, 0 = block fill
- A0 / A1  in  ADDR_W-OFS  block address
- WData0 / WData1  in  WORDS*WORD_W  write block; word i is bits [i*WORD_W +: WORD_W]
- Rdy0 / Rdy1  out  1  one-cycle completion pulse to that port
- RData  out  WORDS*WORD_W  fill buffer; shared by both ports, valid while RdyX=1
- Mem_Req  out  1  memory beat request
- Mem_Wr  out  1  beat is a write
- Mem_Addr  out  ADDR_W  word-aligned address {blk, beat, 2'b00}
- Mem_WData  out  WORD_W  write word for current beat
- Mem_RData  in  WORD_W  read word, valid with Mem_Ack
- Mem_Ack  in  1  beat complete (one cycle per beat)

## Operation
- States: IDLE, XFER, DONE. The state register, beat counter (BW bits), owner bit, last-grant bit, latched Wr, latched block address, latched write block and read buffer are all registered.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both requests: grant the port that is not last-grant.
  - On grant: latch owner, Wr, A and WData. Set beat=0, set last-grant=owner, go to XFER.
- XFER:
  - Mem_Req=1, Mem_Wr=latched Wr, Mem_Addr={blk, beat, 2'b00}.
  - Mem_WData = latched word[beat].
  - On Mem_Ack:
    - Read beat: buffer[beat] <= Mem_RData.
    - beat == WORDS-1: go to DONE.
    - Otherwise: beat <= beat+1.
  - Without Mem_Ack, all signals hold.
- DONE: Rdy[owner]=1 for exactly this cycle, then go to IDLE. RData holds the buffer contents until the next read beat overwrites them.
- Outputs in IDLE and DONE: Mem_Req=0, Mem_Wr=0, Mem_Addr=0, Mem_WData=0.
- RdyX is decoded from state==DONE and owner.
- RData is driven directly from the buffer; it is not gated.
- Requests are sampled only in IDLE.
  - A requester dropping Req mid-transfer does not abort it; the transfer completes and Rdy still pulses.
  - The non-owner's Req stays pending until the next IDLE.
- Mem_Ack outside XFER is ignored.
- The beat counter wraps naturally. No beat beyond WORDS-1 is ever issued.
- Write-back followed by fill (the cache's WB then MB sequence) is two independent transfers. Round-robin may interleave the other port between them.

## Timing
- Reset (rst=0, asynchronous) or reset mid-transfer puts the block in this state immediately:
  - state=IDLE, beat=0, owner=0, last-grant=1 (so port 0 wins the first tie).
  - Buffer = 0 and all outputs = 0.
  - No Rdy pulse for the aborted transfer.
- Request sampled in IDLE at edge t:
  - XFER from cycle t+1.
  - With zero-wait memory (Mem_Ack in the same cycle as Mem_Req), beats occupy t+1..t+WORDS.
  - DONE (Rdy=1) at cycle t+WORDS+1.
  - IDLE at cycle t+WORDS+2.
- Minimum turnaround is 2 cycles of overhead per block: one IDLE cycle and one DONE cycle.
- Back-to-back requests: the requester lowers Req the cycle after Rdy, so the IDLE cycle after DONE grants the other port if it is pending.
- Each Mem_Ack advances exactly one beat. Wait states of any length are allowed.

## Test plan
- Single fill, port 0:
  - Stimulus: A0=0x0000123, memory returns 0xA0..0xA3 with zero wait.
  - Required: Mem_Addr 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; Rdy0 pulses 5 cycles after grant; RData = {A3,A2,A1,A0}; Rdy1 stays 0.
- Write-back, port 1:
  - Stimulus: Wr1=1, WData1 = {D3..D0}, Mem_Ack delayed 2 cycles per beat.
  - Required: Mem_Wr=1, Mem_WData = D0..D3 in order, each held until its ack; Rdy1 pulses once, after the 4th ack.
- Simultaneous Req0 and Req1 repeated 3 times:
  - Required: after reset, grants go 0, 1, 0.
  - Also: Req1 held through port 0's transfer is served immediately after port 0's DONE.
- Req0 dropped during beat 1:
  - Required: beats 2 and 3 are still issued; Rdy0 still pulses.
- Reset asserted during beat 2:
  - Required: Mem_Req=0 immediately; no Rdy pulse.
  - After release: a new Req1 starts at beat 0.
- Spurious Mem_Ack in IDLE and DONE:
  - Required: no buffer change, no state change.
